// File: rtl/asip_execute_module.sv
`default_nettype none
// ============================================================================
// Module   : asip_execute_module
// Purpose  : Execute stage of the vector ASIP pipeline for alpha composition.
//            Forwards operands from the MEM (2) and WB (3) stages, extends
//            operand B, runs a 32-bit scalar / 16x8-bit vector ALU, and keeps
//            Z/N condition flags that select the branch output.
// Ports    : clk        - pipeline clock, rising edge
//            rst        - asynchronous active-low reset (clears flags)
//            CondEn1    - instruction updates condition flags
//            jmpF1      - jump type (00 none, 01 always, 10 if Z, 11 if !Z)
//            ALUIns1    - ALU operation code
//            ExtndSel1  - operand-B extension select
//            R2_V2_D1   - source A index,  R2_V2_1 - source A value
//            R3_V3_D1   - source B index,  R3_V3_1 - source B value/immediate
//            VF1/VF2/VF3 - vector flag of EX / MEM / WB instruction
//            R_V_dest2, ALURES2 - MEM-stage destination and result
//            R_V_dest3, ResRV   - WB-stage destination and result
//            JmpSel     - take branch (combinational from registered flags)
//            ALURES1    - execute result (combinational)
// Options  : EXEC_SAT_EN - when defined, vector ADD/SUB saturate per lane
//            to [0,255]; otherwise all arithmetic wraps.
// Revision : 1.0 - initial release
// ============================================================================
module asip_execute_module (
  input  logic         clk,
  input  logic         rst,
  input  logic         CondEn1,
  input  logic [1:0]   jmpF1,
  input  logic [2:0]   ALUIns1,
  input  logic [1:0]   ExtndSel1,
  input  logic [3:0]   R2_V2_D1,
  input  logic [3:0]   R3_V3_D1,
  input  logic [127:0] R2_V2_1,
  input  logic [127:0] R3_V3_1,
  input  logic         VF1,
  input  logic         VF2,
  input  logic [3:0]   R_V_dest2,
  input  logic [127:0] ALURES2,
  input  logic         VF3,
  input  logic [3:0]   R_V_dest3,
  input  logic [127:0] ResRV,
  output logic         JmpSel,
  output logic [127:0] ALURES1
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MULH  = 3'b011;
  localparam logic [2:0] OP_SRL   = 3'b100;
  localparam logic [2:0] OP_SLL   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;

  logic [127:0] op_a;
  logic [127:0] fwd_b;
  logic [127:0] op_b;
  logic [127:0] vec_res;
  logic [31:0]  sc_res;
  logic [63:0]  sc_prod;
  logic         z_flag;
  logic         n_flag;

  // Forwarding: MEM stage beats WB stage; index 0 and VF mismatches never hit.
  always_comb begin
    op_a = R2_V2_1;
    if (R2_V2_D1 != 4'd0 && R2_V2_D1 == R_V_dest2 && VF2 == VF1)
      op_a = ALURES2;
    else if (R2_V2_D1 != 4'd0 && R2_V2_D1 == R_V_dest3 && VF3 == VF1)
      op_a = ResRV;
  end

  always_comb begin
    fwd_b = R3_V3_1;
    if (R3_V3_D1 != 4'd0 && R3_V3_D1 == R_V_dest2 && VF2 == VF1)
      fwd_b = ALURES2;
    else if (R3_V3_D1 != 4'd0 && R3_V3_D1 == R_V_dest3 && VF3 == VF1)
      fwd_b = ResRV;
  end

  // Extended forms treat B as an immediate, so only the pass-through form
  // takes the forwarded value.
  always_comb begin
    unique case (ExtndSel1)
      2'b00:   op_b = fwd_b;
      2'b01:   op_b = {112'd0, R3_V3_1[15:0]};
      2'b10:   op_b = {96'd0, {16{R3_V3_1[15]}}, R3_V3_1[15:0]};
      default: op_b = {16{R3_V3_1[7:0]}};
    endcase
  end

  // Scalar datapath on bits [31:0]
  assign sc_prod = {32'd0, op_a[31:0]} * {32'd0, op_b[31:0]};

  always_comb begin
    unique case (ALUIns1)
      OP_ADD:   sc_res = op_a[31:0] + op_b[31:0];
      OP_SUB:   sc_res = op_a[31:0] - op_b[31:0];
      OP_MUL:   sc_res = sc_prod[31:0];
      OP_MULH:  sc_res = sc_prod[63:32];
      OP_SRL:   sc_res = op_a[31:0] >> op_b[4:0];
      OP_SLL:   sc_res = op_a[31:0] << op_b[4:0];
      OP_PASSB: sc_res = op_b[31:0];
      default:  sc_res = op_a[31:0] & op_b[31:0];
    endcase
  end

  // Vector datapath: sixteen isolated 8-bit lanes
  generate
    for (genvar i = 0; i < 16; i++) begin : g_lane
      logic [7:0]  a8;
      logic [7:0]  b8;
      logic [15:0] prod;
      logic [7:0]  add_r;
      logic [7:0]  sub_r;

      assign a8   = op_a[8*i +: 8];
      assign b8   = op_b[8*i +: 8];
      assign prod = {8'd0, a8} * {8'd0, b8};

`ifdef EXEC_SAT_EN
      logic [8:0] sum9;
      logic [8:0] diff9;
      assign sum9  = {1'b0, a8} + {1'b0, b8};
      assign diff9 = {1'b0, a8} - {1'b0, b8};
      // Carry-out clamps high; borrow-out clamps to zero.
      assign add_r = sum9[8]  ? 8'hFF : sum9[7:0];
      assign sub_r = diff9[8] ? 8'h00 : diff9[7:0];
`else
      assign add_r = a8 + b8;
      assign sub_r = a8 - b8;
`endif

      always_comb begin
        unique case (ALUIns1)
          OP_ADD:   vec_res[8*i +: 8] = add_r;
          OP_SUB:   vec_res[8*i +: 8] = sub_r;
          OP_MUL:   vec_res[8*i +: 8] = prod[7:0];
          OP_MULH:  vec_res[8*i +: 8] = prod[15:8];
          OP_SRL:   vec_res[8*i +: 8] = a8 >> b8[2:0];
          OP_SLL:   vec_res[8*i +: 8] = a8 << b8[2:0];
          OP_PASSB: vec_res[8*i +: 8] = b8;
          default:  vec_res[8*i +: 8] = a8 & b8;
        endcase
      end
    end
  endgenerate

  assign ALURES1 = VF1 ? vec_res : {96'd0, sc_res};

  // Condition flags. Scalar results already have zeroed upper bits, so the
  // full-width zero test covers both modes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (CondEn1) begin
      z_flag <= (ALURES1 == 128'd0);
      n_flag <= VF1 ? ALURES1[127] : ALURES1[31];
    end
  end

  always_comb begin
    unique case (jmpF1)
      2'b00:   JmpSel = 1'b0;
      2'b01:   JmpSel = 1'b1;
      2'b10:   JmpSel = z_flag;
      default: JmpSel = ~z_flag;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_asip_execute_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_asip_execute_module
// Purpose  : Self-checking bench for asip_execute_module. A driver applies
//            directed and random instructions and pushes expected results
//            from a behavioural model into a queue; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asip_execute_module;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         CondEn1 = 1'b0;
  logic [1:0]   jmpF1 = 2'b00;
  logic [2:0]   ALUIns1 = 3'b000;
  logic [1:0]   ExtndSel1 = 2'b00;
  logic [3:0]   R2_V2_D1 = 4'd0;
  logic [3:0]   R3_V3_D1 = 4'd0;
  logic [127:0] R2_V2_1 = '0;
  logic [127:0] R3_V3_1 = '0;
  logic         VF1 = 1'b0;
  logic         VF2 = 1'b0;
  logic [3:0]   R_V_dest2 = 4'd0;
  logic [127:0] ALURES2 = '0;
  logic         VF3 = 1'b0;
  logic [3:0]   R_V_dest3 = 4'd0;
  logic [127:0] ResRV = '0;
  logic         JmpSel;
  logic [127:0] ALURES1;

  asip_execute_module dut (
    .clk(clk), .rst(rst), .CondEn1(CondEn1), .jmpF1(jmpF1),
    .ALUIns1(ALUIns1), .ExtndSel1(ExtndSel1),
    .R2_V2_D1(R2_V2_D1), .R3_V3_D1(R3_V3_D1),
    .R2_V2_1(R2_V2_1), .R3_V3_1(R3_V3_1),
    .VF1(VF1), .VF2(VF2), .R_V_dest2(R_V_dest2), .ALURES2(ALURES2),
    .VF3(VF3), .R_V_dest3(R_V_dest3), .ResRV(ResRV),
    .JmpSel(JmpSel), .ALURES1(ALURES1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] res;
    logic         jmp;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_z = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Operand source per the forwarding rules: MEM first, then WB, then register.
  function automatic logic [127:0] model_src(input logic [3:0] idx, input logic [127:0] regv);
    if (idx != 0 && idx == R_V_dest2 && VF2 == VF1) return ALURES2;
    if (idx != 0 && idx == R_V_dest3 && VF3 == VF1) return ResRV;
    return regv;
  endfunction

  function automatic logic [127:0] model_alu(input logic [2:0] op, input logic vf,
                                             input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    logic [31:0]  x, y, s;
    logic [63:0]  p;
    int           xi, yi, ri;
    r = '0;
    if (!vf) begin
      x = a[31:0];
      y = b[31:0];
      p = 64'(x) * 64'(y);
      case (op)
        3'd0: s = x + y;
        3'd1: s = x - y;
        3'd2: s = p[31:0];
        3'd3: s = p[63:32];
        3'd4: s = x >> y[4:0];
        3'd5: s = x << y[4:0];
        3'd6: s = y;
        default: s = x & y;
      endcase
      r[31:0] = s;
    end else begin
      for (int i = 0; i < 16; i++) begin
        xi = int'(a[8*i +: 8]);
        yi = int'(b[8*i +: 8]);
        case (op)
          3'd0: begin
            ri = xi + yi;
`ifdef EXEC_SAT_EN
            if (ri > 255) ri = 255;
`endif
          end
          3'd1: begin
            ri = xi - yi;
`ifdef EXEC_SAT_EN
            if (ri < 0) ri = 0;
`endif
          end
          3'd2: ri = xi * yi;
          3'd3: ri = (xi * yi) / 256;
          3'd4: ri = xi >> (yi % 8);
          3'd5: ri = xi << (yi % 8);
          3'd6: ri = yi;
          default: ri = xi & yi;
        endcase
        r[8*i +: 8] = 8'(ri & 255);
      end
    end
    return r;
  endfunction

  // Compute the expected response of the currently driven inputs and queue it.
  task automatic issue(input string nm);
    exp_t e;
    logic [127:0] a, b;
    a = model_src(R2_V2_D1, R2_V2_1);
    case (ExtndSel1)
      2'b00: b = model_src(R3_V3_D1, R3_V3_1);
      2'b01: b = 128'(R3_V3_1[15:0]);
      2'b10: b = 128'({{16{R3_V3_1[15]}}, R3_V3_1[15:0]});
      default: b = {16{R3_V3_1[7:0]}};
    endcase
    e.res  = model_alu(ALUIns1, VF1, a, b);
    case (jmpF1)
      2'b00: e.jmp = 1'b0;
      2'b01: e.jmp = 1'b1;
      2'b10: e.jmp = model_z;
      default: e.jmp = !model_z;
    endcase
    e.name = nm;
    sb_q.push_back(e);
    if (CondEn1) model_z = (e.res == 128'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    CondEn1 = 0; jmpF1 = 0; ALUIns1 = 0; ExtndSel1 = 0;
    R2_V2_D1 = 4'd2; R3_V3_D1 = 4'd3; R2_V2_1 = '0; R3_V3_1 = '0;
    VF1 = 0; VF2 = 0; VF3 = 0; R_V_dest2 = 4'd4; R_V_dest3 = 4'd4;
    ALURES2 = '0; ResRV = '0;
  endtask

  // Monitor: the result is combinational, so it is valid by the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, "_res"}, ALURES1, e.res);
      check({e.name, "_jmp"}, 128'(JmpSel), 128'(e.jmp));
    end
  end

  initial begin
    int wait_cnt;
    clear_inputs();
    // Flags cleared in reset: JmpSel follows jmpF1 with Z = 0
    #1;
    jmpF1 = 2'b10; #1 check("rst_jmp10", 128'(JmpSel), 128'd0);
    jmpF1 = 2'b11; #1 check("rst_jmp11", 128'(JmpSel), 128'd1);
    jmpF1 = 2'b01; #1 check("rst_jmp01", 128'(JmpSel), 128'd1);
    jmpF1 = 2'b00;
    next_cycle();
    rst = 1'b1;

    // Scalar multiply, no hazard
    next_cycle(); clear_inputs();
    ALUIns1 = 3'b010; R2_V2_1 = 128'hA; R3_V3_1 = 128'h2;
    issue("scalar_mul");

    // Forwarding priority
    next_cycle(); clear_inputs();
    R_V_dest2 = 4'd2; R_V_dest3 = 4'd2; ALURES2 = 128'h5; ResRV = 128'h9;
    R2_V2_1 = 128'hA; R3_V3_1 = 128'h1;
    issue("fwd_stage2");
    next_cycle(); R_V_dest2 = 4'd7; issue("fwd_stage3");
    next_cycle(); VF3 = 1'b1;      issue("fwd_vf_block");

    // Vector lanes
    next_cycle(); clear_inputs();
    VF1 = 1'b1; R2_V2_1 = {16{8'hF0}}; R3_V3_1 = 128'h20; ExtndSel1 = 2'b11;
    issue("vec_add_bcast");
    next_cycle(); ALUIns1 = 3'b011; R2_V2_1 = {16{8'hFF}}; R3_V3_1 = 128'h80;
    issue("vec_mulh");
    next_cycle(); ALUIns1 = 3'b001; R2_V2_1 = {16{8'h10}}; R3_V3_1 = 128'h30;
    issue("vec_sub_under");

    // Extension
    next_cycle(); clear_inputs();
    ALUIns1 = 3'b110; R3_V3_1 = 128'hFFFF8000; ExtndSel1 = 2'b10;
    issue("ext_sign16");
    next_cycle(); ExtndSel1 = 2'b01; issue("ext_zero16");

    // Flags and jump
    next_cycle(); clear_inputs();
    ALUIns1 = 3'b001; R2_V2_1 = 128'h5; R3_V3_1 = 128'h5; CondEn1 = 1'b1; jmpF1 = 2'b10;
    issue("cmp_same_cycle");
    next_cycle(); CondEn1 = 1'b0; issue("cmp_next_z");
    next_cycle(); jmpF1 = 2'b11; issue("cmp_next_nz");

    // Asynchronous reset mid-cycle
    next_cycle(); jmpF1 = 2'b10;
    #1 check("pre_reset_z", 128'(JmpSel), 128'd1);
    #2 rst = 1'b0;
    #1 check("async_reset", 128'(JmpSel), 128'd0);
    model_z = 1'b0;
    next_cycle(); rst = 1'b1;

    // Randomized traffic with small index ranges to provoke hazards
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      CondEn1   = 1'($urandom_range(0, 1));
      jmpF1     = 2'($urandom_range(0, 3));
      ALUIns1   = 3'($urandom_range(0, 7));
      ExtndSel1 = 2'($urandom_range(0, 3));
      R2_V2_D1  = 4'($urandom_range(0, 3));
      R3_V3_D1  = 4'($urandom_range(0, 3));
      R_V_dest2 = 4'($urandom_range(0, 3));
      R_V_dest3 = 4'($urandom_range(0, 3));
      VF1 = 1'($urandom_range(0, 1));
      VF2 = 1'($urandom_range(0, 1));
      VF3 = 1'($urandom_range(0, 1));
      R2_V2_1 = rnd128(); R3_V3_1 = rnd128();
      ALURES2 = rnd128(); ResRV = rnd128();
      // Sparse operands make zero results (and Z) reachable
      if ($urandom_range(0, 3) == 0) begin
        R2_V2_1 = '0; R3_V3_1 = '0; ALURES2 = '0; ResRV = '0;
      end
      issue("rand");
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
